// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode codes, vote helper.
// Latency: n/a (types, constants and one combinational function only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Majority of three samples; used for the per-bit vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser on the serial pin plus a 3-tap majority history.
// Latency: line change visible on rx_sync after 2 edges; rx_vote follows majority of last 3 syncs.
// Backpressure: none; free-running every clock.
module uart_rx_sync_vote (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Rx_Serial,
  output logic rx_sync,
  output logic rx_vote
);
  import uart_pkg::*;

  logic meta_q;
  logic sync_q;
  logic hist1_q;
  logic hist2_q;

  // Synchroniser and history shift; everything resets to the idle line level.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      meta_q  <= i_Rx_Serial;
      sync_q  <= meta_q;
      hist1_q <= sync_q;
      hist2_q <= hist1_q;
    end
  end

  assign rx_sync = sync_q;
  assign rx_vote = maj3(sync_q, hist1_q, hist2_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: N data bits, optional odd/even parity, 1 or 2 stop bits.
// Latency: DV one edge after the last stop-bit sample point (mid stop bit).
// Backpressure: none; consumer must take o_Rx_Byte and flags in the DV cycle.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);
  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam bit ODD_PARITY = (PARITY_MODE == PARITY_ODD);
  localparam bit TWO_STOP   = (STOP_BITS == 2);

  // Reject unsupported configurations at elaboration time.
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_rx_param: CLKS_PER_BIT must be 4..65535");
  end

  rx_state_t     state;
  logic [CW-1:0] clk_count;
  logic [IW-1:0] bit_index;
  logic          stop_index;
  logic          par_acc;
  logic          par_err_q;
  logic          frame_err_q;
  logic          all_zero_q;
  logic          rx_sync;
  logic          rx_vote;
  logic          bit_end;

  uart_rx_sync_vote u_sync_vote (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (i_Rx_Serial),
    .rx_sync     (rx_sync),
    .rx_vote     (rx_vote)
  );

  assign bit_end = (clk_count == CNT_LAST);

  // Frame FSM: bit timing, data capture, error/break accumulation and registered outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= ST_IDLE;
      clk_count    <= '0;
      bit_index    <= '0;
      stop_index   <= 1'b0;
      par_acc      <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      all_zero_q   <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      // DV and flags are single-cycle; only the last stop bit raises them.
      o_Rx_DV      <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;

      case (state)
        ST_IDLE: begin
          clk_count   <= '0;
          bit_index   <= '0;
          stop_index  <= 1'b0;
          par_acc     <= 1'b0;
          par_err_q   <= 1'b0;
          frame_err_q <= 1'b0;
          all_zero_q  <= 1'b1;
          if (!rx_sync) begin
            state  <= ST_START;
            o_Busy <= 1'b1;
          end
        end

        ST_START: begin
          // Raw line at mid start bit: still low means a real start, else a glitch.
          if (clk_count == CNT_HALF) begin
            clk_count <= '0;
            if (!rx_sync) begin
              state <= ST_DATA;
            end else begin
              state  <= ST_IDLE;
              o_Busy <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + CW'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            clk_count              <= '0;
            o_Rx_Byte[bit_index]   <= rx_vote;
            par_acc                <= par_acc ^ rx_vote;
            all_zero_q             <= all_zero_q & ~rx_vote;
            if (bit_index == IDX_LAST) begin
              bit_index <= '0;
              state     <= HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              bit_index <= bit_index + IW'(1);
            end
          end else begin
            clk_count <= clk_count + CW'(1);
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            clk_count  <= '0;
            all_zero_q <= all_zero_q & ~rx_vote;
            // Odd: total ones must be odd (XOR = 1); even: XOR must be 0.
            par_err_q  <= ODD_PARITY ? ~(par_acc ^ rx_vote) : (par_acc ^ rx_vote);
            state      <= ST_STOP;
          end else begin
            clk_count <= clk_count + CW'(1);
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            clk_count <= '0;
            if (!TWO_STOP || stop_index) begin
              o_Rx_DV      <= 1'b1;
              o_Parity_Err <= par_err_q;
              o_Frame_Err  <= frame_err_q | ~rx_vote;
              o_Break      <= all_zero_q & ~rx_vote;
              state        <= ST_CLEANUP;
            end else begin
              stop_index  <= 1'b1;
              frame_err_q <= frame_err_q | ~rx_vote;
              all_zero_q  <= all_zero_q & ~rx_vote;
            end
          end else begin
            clk_count <= clk_count + CW'(1);
          end
        end

        ST_CLEANUP: begin
          // A bad stop bit means the line may still be low: wait for it to recover.
          if (o_Frame_Err) begin
            state <= ST_WAIT_HIGH;
          end else begin
            state  <= ST_IDLE;
            o_Busy <= 1'b0;
          end
        end

        ST_WAIT_HIGH: begin
          if (rx_sync) begin
            state  <= ST_IDLE;
            o_Busy <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver.
- Configurable data width, parity (none/odd/even) and 1 or 2 stop bits.
- 3-sample majority vote at each sample point; glitch rejection on the start bit.
- Reports parity error, framing error and break conditions.
- Sits between the board serial pin and the downstream byte consumer (downsampling processor command/data path), replacing the fixed 8N1 receiver.

Parameters:
CLKS_PER_BIT, 87, clock cycles per bit = f(i_Clock)/baud; legal range 4..65535
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even; 3 is illegal and must be rejected at elaboration
STOP_BITS, 1, stop bits checked per frame; legal 1 or 2

Ports:
i_Clock  in  1  single system clock, rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Rx_Serial  in  1  asynchronous serial line, idle high
o_Rx_DV  out  1  one-cycle pulse: frame complete; o_Rx_Byte and error flags valid this cycle
o_Rx_Byte  out  DATA_BITS  received data, LSB = first bit on line; held until next DV
o_Parity_Err  out  1  with DV: parity mismatch (always 0 when PARITY_MODE = 0)
o_Frame_Err  out  1  with DV: any checked stop bit sampled 0
o_Break  out  1  with DV: data all 0, parity bit (if present) 0, and stop bit(s) 0
o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state, mid-frame included):
  - state = IDLE; counters = 0.
  - Both synchroniser flops and the vote history = 1.
  - All outputs = 0, o_Rx_Byte included.
- Synchroniser: 2 flops on i_Rx_Serial. A line fall is first seen by the FSM at the 3rd rising edge after the fall; call this edge E0.
- Vote: a 3-bit history of synchronised samples. The bit value at a sample point is the majority of the current synchronised value and the previous two.
- Counter width is $clog2(CLKS_PER_BIT); H = (CLKS_PER_BIT-1)/2, integer division.
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
- IDLE: count = 0, bit index = 0. Synchronised line = 0 -> START.
- START:
  - Count up from 0.
  - At count == H, the raw synchronised line is checked (no vote).
  - Line 0 -> count = 0, go DATA.
  - Line 1 -> go IDLE: glitch rejected, no DV.
- DATA: count 0..CLKS_PER_BIT-1.
  - At count == CLKS_PER_BIT-1: store the vote into o_Rx_Byte[index] and reset count.
  - After index DATA_BITS-1: go PARITY if PARITY_MODE != 0, else go STOP.
- PARITY: same timing as one data bit.
  - Odd mode: error if XOR(data, parity bit) != 1.
  - Even mode: error if XOR(data, parity bit) != 0.
- STOP: same timing per stop bit, repeated STOP_BITS times; any stop bit voted 0 sets frame error.
  - At the end of the last stop bit: o_Rx_DV = 1 together with the flags, then go CLEANUP.
- Byte register: o_Rx_Byte is updated bit by bit during DATA. Consumers sample it only on DV.
- Timing: bit k (start = bit 0) is sampled at edge E0+H+1+k*CLKS_PER_BIT. DV is high for exactly the cycle after edge E0+H+1+(DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT, where P = 1 if parity is enabled.
- CLEANUP: DV = 0, error flags = 0.
  - Frame error -> WAIT_HIGH.
  - Otherwise -> IDLE.
- WAIT_HIGH: stay until the synchronised line = 1, then go IDLE. A held-low line or break therefore produces exactly one DV.
- Flags are 0 whenever DV = 0.
- A new start edge arriving during CLEANUP is caught in IDLE on the next cycle (one cycle late). This is tolerated because start alignment is to the bit middle.

Decomposition:
- Package uart_pkg: state encodings and the PARITY_NONE/ODD/EVEN constants. These are shared with the planned parametrised transmitter.
- Sub-module uart_rx_sync_vote: 2-flop synchroniser plus 3-tap majority history.
  - Async reset to 1.
  - Outputs: synchronised bit, voted bit.

Test Plan:
1. CLKS_PER_BIT=16, 8N1; send 0xA5 with the line falling before edge 1 -> single DV pulse after edge 155; o_Rx_Byte = 0xA5; all flags 0.
2. DATA_BITS=7, even parity; send 0x41 with parity 0 -> DV, byte 0x41, parity err 0. Resend with parity 1 -> DV, byte 0x41, o_Parity_Err = 1.
3. 8N2; send 0x3C with second stop bit 0 -> DV with o_Frame_Err = 1. Hold the line low 3 bit times -> no further DV. Line high, then send 0x5A -> DV, byte 0x5A, no errors.
4. Break: line low for 20 bit times (8N1) -> exactly one DV with byte 0x00, o_Break = 1, o_Frame_Err = 1; o_Busy stays high until the line returns high.
5. Noise: 4-cycle low pulse on an idle line -> no DV, o_Busy back to 0. Then one inverted cycle exactly at the bit-2 sample point of frame 0xFF -> byte 0xFF, no error.
6. Assert i_Reset mid-cycle during data bit 3 of a frame -> all outputs 0 immediately, before the next clock edge. Release, then send full frame 0xC3 -> DV, byte 0xC3, no errors.
